// File: rtl/cheshire_board_rst_ctrl_if.sv
// Board-side reset/strap signal bundle between the board pins and the reset sequencer.
interface cheshire_board_rst_ctrl_if;
    logic       btn_rst_i;
    logic       sw_rst_req_i;
    logic [1:0] boot_mode_i;
    logic       test_mode_i;
    logic       soc_rst_no;
    logic [1:0] boot_mode_o;
    logic       test_mode_o;
    logic [7:0] rst_cnt_o;

    modport slave (
        input  btn_rst_i,
        input  sw_rst_req_i,
        input  boot_mode_i,
        input  test_mode_i,
        output soc_rst_no,
        output boot_mode_o,
        output test_mode_o,
        output rst_cnt_o
    );

    modport master (
        output btn_rst_i,
        output sw_rst_req_i,
        output boot_mode_i,
        output test_mode_i,
        input  soc_rst_no,
        input  boot_mode_o,
        input  test_mode_o,
        input  rst_cnt_o
    );
endinterface

// File: rtl/cheshire_board_rst_ctrl.sv
// Board reset sequencer: synchronizes and debounces the reset button, stretches the SoC reset
// and latches boot straps on every reset release.
module cheshire_board_rst_ctrl #(
    parameter int unsigned SyncStages     = 2,
    parameter int unsigned DebounceCycles = 50000,
    parameter int unsigned HoldCycles     = 1024,
    parameter bit          BtnActiveHigh  = 1'b1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    cheshire_board_rst_ctrl_if.slave        bus
);

    localparam int unsigned DbW = $clog2(DebounceCycles + 1);
    localparam int unsigned HcW = $clog2(HoldCycles + 1);
    localparam logic [DbW-1:0] DbLast   = DbW'(DebounceCycles - 1);
    localparam logic [HcW-1:0] HoldLast = HcW'(HoldCycles - 1);

    localparam logic [1:0] StHold    = 2'd0;
    localparam logic [1:0] StRun     = 2'd1;
    localparam logic [1:0] StPressed = 2'd2;

    logic [SyncStages-1:0]      btn_sync_q;
    logic [SyncStages-1:0][1:0] boot_sync_q;
    logic [SyncStages-1:0]      test_sync_q;

    logic           btn_norm;
    logic           db_q, db_d;
    logic [DbW-1:0] db_cnt_q, db_cnt_d;

    logic [1:0]     state_q, state_d;
    logic [HcW-1:0] hold_cnt_q, hold_cnt_d;
    logic [7:0]     rst_cnt_q, rst_cnt_d;
    logic           soc_rst_n_q;
    logic [1:0]     boot_q, boot_d;
    logic           test_q, test_d;
    logic           strap_load;

    assign btn_norm = BtnActiveHigh ? btn_sync_q[SyncStages-1] : ~btn_sync_q[SyncStages-1];

    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        if (btn_norm != db_q) begin
            if (db_cnt_q == DbLast) begin
                db_d = ~db_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // The FSM reacts to the debounced value on the same edge it flips.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        rst_cnt_d  = rst_cnt_q;
        case (state_q)
            StHold: begin
                if (db_d) begin
                    state_d    = StPressed;
                    hold_cnt_d = '0;
                end else if (bus.sw_rst_req_i) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HoldLast) begin
                    state_d    = StRun;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (db_d) begin
                    state_d = StPressed;
                    if (rst_cnt_q != 8'hff) begin
                        rst_cnt_d = rst_cnt_q + 8'd1;
                    end
                end else if (bus.sw_rst_req_i) begin
                    state_d    = StHold;
                    hold_cnt_d = '0;
                end
            end
            StPressed: begin
                if (!db_d) begin
                    state_d    = StHold;
                    hold_cnt_d = '0;
                end
            end
            default: begin
                state_d    = StHold;
                hold_cnt_d = '0;
            end
        endcase
    end

    assign strap_load = (state_d == StRun) && (state_q != StRun);

    always_comb begin
        boot_d = boot_q;
        test_d = test_q;
        if (strap_load) begin
            boot_d = boot_sync_q[SyncStages-1];
            test_d = test_sync_q[SyncStages-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            btn_sync_q  <= '0;
            boot_sync_q <= '0;
            test_sync_q <= '0;
            db_q        <= 1'b0;
            db_cnt_q    <= '0;
            state_q     <= StHold;
            hold_cnt_q  <= '0;
            rst_cnt_q   <= 8'd0;
            soc_rst_n_q <= 1'b0;
            boot_q      <= 2'b00;
            test_q      <= 1'b0;
        end else begin
            btn_sync_q  <= {btn_sync_q[SyncStages-2:0], bus.btn_rst_i};
            boot_sync_q <= {boot_sync_q[SyncStages-2:0], bus.boot_mode_i};
            test_sync_q <= {test_sync_q[SyncStages-2:0], bus.test_mode_i};
            db_q        <= db_d;
            db_cnt_q    <= db_cnt_d;
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            rst_cnt_q   <= rst_cnt_d;
            soc_rst_n_q <= (state_d == StRun);
            boot_q      <= boot_d;
            test_q      <= test_d;
        end
    end

    assign bus.soc_rst_no  = soc_rst_n_q;
    assign bus.boot_mode_o = boot_q;
    assign bus.test_mode_o = test_q;
    assign bus.rst_cnt_o   = rst_cnt_q;

endmodule

// File: tb/tb_cheshire_board_rst_ctrl.sv
// Randomized bench for the board reset sequencer against an edge-indexed behavioural model.
module tb_cheshire_board_rst_ctrl;

    localparam int unsigned S = 2;
    localparam int unsigned D = 4;
    localparam int unsigned H = 8;

    logic clk_i;
    logic rst_ni;

    cheshire_board_rst_ctrl_if bus ();

    cheshire_board_rst_ctrl #(
        .SyncStages    (S),
        .DebounceCycles(D),
        .HoldCycles    (H),
        .BtnActiveHigh (1'b1)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus.slave)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: raw samples indexed backwards from the current edge; the SoC leaves reset at a
    // precomputed edge number HoldCycles after its last cause cleared.
    bit         m_btn_h[$];
    logic [1:0] m_boot_h[$];
    bit         m_test_h[$];
    bit         m_db, m_run, m_press, m_test;
    logic [1:0] m_boot;
    int         m_edge, m_run_at, m_cnt;

    function automatic bit btn_at(int i);
        return (i < m_btn_h.size()) ? m_btn_h[i] : 1'b0;
    endfunction

    function automatic logic [1:0] boot_at(int i);
        return (i < m_boot_h.size()) ? m_boot_h[i] : 2'b00;
    endfunction

    function automatic bit test_at(int i);
        return (i < m_test_h.size()) ? m_test_h[i] : 1'b0;
    endfunction

    task automatic model_reset();
        m_btn_h.delete();
        m_boot_h.delete();
        m_test_h.delete();
        m_db = 0; m_run = 0; m_press = 0; m_test = 0; m_boot = 2'b00;
        m_edge = 0; m_run_at = H; m_cnt = 0;
    endtask

    task automatic model_edge();
        bit flip;
        m_btn_h.push_front(bus.btn_rst_i);
        m_boot_h.push_front(bus.boot_mode_i);
        m_test_h.push_front(bus.test_mode_i);
        if (m_btn_h.size() > S + D) begin
            void'(m_btn_h.pop_back());
            void'(m_boot_h.pop_back());
            void'(m_test_h.pop_back());
        end
        m_edge++;
        // Debounced value flips once D consecutive synced samples disagree with it.
        flip = 1;
        for (int k = 0; k < D; k++) if (btn_at(S + k) == m_db) flip = 0;
        if (flip) m_db = !m_db;

        if (m_run) begin
            if (m_db) begin
                m_run = 0; m_press = 1;
                if (m_cnt < 255) m_cnt++;
            end else if (bus.sw_rst_req_i) begin
                m_run = 0; m_run_at = m_edge + H;
            end
        end else if (m_press) begin
            if (!m_db) begin
                m_press = 0; m_run_at = m_edge + H;
            end
        end else if (m_db) begin
            m_press = 1;
        end else if (bus.sw_rst_req_i) begin
            m_run_at = m_edge + H;
        end else if (m_edge == m_run_at) begin
            m_run = 1; m_boot = boot_at(S); m_test = test_at(S);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
        check_eq("soc_rst_n", 32'(bus.soc_rst_no), 32'(m_run));
        check_eq("boot_mode", 32'(bus.boot_mode_o), 32'(m_boot));
        check_eq("test_mode", 32'(bus.test_mode_o), 32'(m_test));
        check_eq("rst_cnt", 32'(bus.rst_cnt_o), 32'(m_cnt));
    endtask

    task automatic wait_soc(input logic val, input int limit, output int n);
        n = 0;
        while (bus.soc_rst_no !== val && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_soc"}, 32'(bus.soc_rst_no), 32'd0);
        check_eq({tag, "_boot"}, 32'(bus.boot_mode_o), 32'd0);
        check_eq({tag, "_test"}, 32'(bus.test_mode_o), 32'd0);
        check_eq({tag, "_cnt"}, 32'(bus.rst_cnt_o), 32'd0);
    endtask

    int n;

    initial begin
        rst_ni           = 1'b0;
        bus.btn_rst_i    = 1'b0;
        bus.sw_rst_req_i = 1'b0;
        bus.boot_mode_i  = 2'b10;
        bus.test_mode_i  = 1'b1;

        // Power-on
        repeat (3) @(negedge clk_i);
        check_reset_vals("por");
        rst_ni = 1'b1;
        model_reset();
        wait_soc(1'b1, 20, n);
        check_eq("por_hold", 32'(n), 32'(H));
        check_eq("por_boot", 32'(bus.boot_mode_o), 32'h2);
        check_eq("por_test", 32'(bus.test_mode_o), 32'h1);

        // Bounce shorter than the debounce window
        bus.btn_rst_i = 1'b1;
        repeat (3) tick();
        bus.btn_rst_i = 1'b0;
        repeat (10) tick();
        check_eq("bounce_soc", 32'(bus.soc_rst_no), 32'd1);
        check_eq("bounce_cnt", 32'(bus.rst_cnt_o), 32'd0);

        // Clean press and release
        bus.btn_rst_i = 1'b1;
        wait_soc(1'b0, 30, n);
        check_eq("press_lat", 32'(n), 32'(S + D));
        repeat (20 - n) tick();
        bus.btn_rst_i = 1'b0;
        wait_soc(1'b1, 40, n);
        check_eq("release_lat", 32'(n), 32'(S + D + H));
        check_eq("press_cnt", 32'(bus.rst_cnt_o), 32'd1);

        // Straps stay put in RUN, reload on re-entry after a software reset
        bus.boot_mode_i = 2'b01;
        repeat (5) tick();
        check_eq("strap_hold", 32'(bus.boot_mode_o), 32'h2);
        bus.sw_rst_req_i = 1'b1;
        tick();
        bus.sw_rst_req_i = 1'b0;
        check_eq("sw_soc", 32'(bus.soc_rst_no), 32'd0);
        wait_soc(1'b1, 20, n);
        check_eq("sw_hold", 32'(n), 32'(H));
        check_eq("strap_reload", 32'(bus.boot_mode_o), 32'h1);
        check_eq("sw_cnt", 32'(bus.rst_cnt_o), 32'd1);

        // Asynchronous reset in the middle of HOLD
        bus.sw_rst_req_i = 1'b1;
        tick();
        bus.sw_rst_req_i = 1'b0;
        repeat (5) tick();
        #2 rst_ni = 1'b0;
        #1 check_reset_vals("mid_hold");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
        repeat (3) tick();
        bus.sw_rst_req_i = 1'b1;
        tick();
        bus.sw_rst_req_i = 1'b0;
        wait_soc(1'b1, 20, n);
        check_eq("restart_hold", 32'(n), 32'(H));

        // Random button/switch/software activity
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) bus.btn_rst_i = ~bus.btn_rst_i;
            bus.sw_rst_req_i = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 31) == 0) bus.boot_mode_i = 2'($urandom);
            if ($urandom_range(0, 31) == 0) bus.test_mode_i = 1'($urandom);
            tick();
        end
        bus.btn_rst_i    = 1'b0;
        bus.sw_rst_req_i = 1'b0;
        wait_soc(1'b1, 60, n);
        check_eq("settle", 32'(bus.soc_rst_no), 32'd1);

        // Counter saturation
        for (int i = 0; i < 260; i++) begin
            bus.btn_rst_i = 1'b1;
            wait_soc(1'b0, 30, n);
            repeat (4) tick();
            bus.btn_rst_i = 1'b0;
            wait_soc(1'b1, 40, n);
        end
        check_eq("sat_cnt", 32'(bus.rst_cnt_o), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/cheshire_board_rst_ctrl.md
Name: cheshire_board_rst_ctrl

Overview:
Board-level reset and strap sequencer. It sits directly upstream of the Cheshire Xilinx top and produces the SoC reset and the latched boot straps that the top consumes. The raw push-button reset is synchronized and debounced, the SoC reset is stretched after release, and boot_mode/test_mode are captured once per reset release. Software/debug reset requests share the same reset path.

Parameters:
SyncStages, 2, synchronizer depth for btn_rst_i, boot_mode_i and test_mode_i (>=2)
DebounceCycles, 50000, consecutive stable cycles required before the debounced button changes (>=1)
HoldCycles, 1024, cycles the SoC reset stays asserted after the last reset cause clears (>=1)
BtnActiveHigh, 1, 1: the button is asserted when btn_rst_i=1; 0: asserted when btn_rst_i=0

Ports:
clk_i  in  1  system clock (MMCM output)
rst_ni  in  1  asynchronous active-low reset (power-on / MMCM locked)
btn_rst_i  in  1  raw board reset button, asynchronous, bouncy
sw_rst_req_i  in  1  synchronous single-cycle software/debug reset request
boot_mode_i  in  2  raw boot-mode switches, asynchronous
test_mode_i  in  1  raw test-mode switch, asynchronous
soc_rst_no  out  1  registered active-low SoC reset
boot_mode_o  out  2  boot mode latched at the last reset release
test_mode_o  out  1  test mode latched at the last reset release
rst_cnt_o  out  8  saturating count of button-induced resets

Behaviour:
- Reset values while rst_ni=0: soc_rst_no=0, boot_mode_o=0, test_mode_o=0, rst_cnt_o=0, state=HOLD, hold counter=0, debounce counter=0, debounced button=0 (released), synchronizer flops=0.
- Synchronizers: btn_rst_i, boot_mode_i and test_mode_i each pass through SyncStages flops. When BtnActiveHigh=0, the button polarity is normalized after the synchronizer.
- Debounce behaviour:
  - The counter increments each cycle the synced button differs from the debounced value.
  - The counter clears to 0 on any cycle where they are equal.
  - When the counter reaches DebounceCycles-1 while the values still differ, the debounced value flips and the counter clears.
  - The counter width is $clog2(DebounceCycles+1).
- FSM states: HOLD, RUN, PRESSED.
  - HOLD: soc_rst_no=0; the hold counter increments each cycle.
    - Debounced press -> PRESSED.
    - sw_rst_req_i -> stay in HOLD with the hold counter cleared.
    - Hold counter reaching HoldCycles-1 -> RUN.
  - RUN: soc_rst_no=1.
    - Debounced press -> PRESSED, and rst_cnt_o increments (saturates at 255).
    - Otherwise sw_rst_req_i -> HOLD with the hold counter cleared.
  - PRESSED: soc_rst_no=0; sw_rst_req_i is ignored.
    - Debounced release -> HOLD with the hold counter cleared.
- Timing of soc_rst_no:
  - soc_rst_no is a flop loaded with (next_state==RUN), so it changes on the same edge as the state register.
  - After rst_ni rises, soc_rst_no rises on the HoldCycles-th clock edge.
- Strap latch:
  - On the edge that enters RUN, boot_mode_o and test_mode_o load the synchronized switch values.
  - They hold constant at all other times, including during HOLD/PRESSED of a later reset, until the next entry into RUN.
- Simultaneous events:
  - In RUN, a press and sw_rst_req_i in the same cycle -> PRESSED, and rst_cnt_o increments.
  - In HOLD, a press wins over sw_rst_req_i.
- A button held forever keeps the FSM in PRESSED indefinitely, with no timeout.
- rst_ni asserted at any point immediately, asynchronously, forces all reset values, including clearing rst_cnt_o.
- Press latency: a clean button edge reaches soc_rst_no=0 after SyncStages+DebounceCycles edges, with ±1 for asynchronous sampling.

Test Plan:
(Params for all: SyncStages=2, DebounceCycles=4, HoldCycles=8, BtnActiveHigh=1.)
1. Power-on: rst_ni low 3 cycles, then high; button idle; boot_mode_i=2'b10, test_mode_i=1 -> soc_rst_no=0 for exactly 8 edges, then 1; boot_mode_o=2'b10, test_mode_o=1.
2. Bounce rejection: in RUN, btn_rst_i high 3 cycles then low -> soc_rst_no stays 1, rst_cnt_o stays 0.
3. Clean press: btn_rst_i high for 20 cycles, then low -> soc_rst_no falls ~6 edges after the press; it rises 8 edges after the debounced release; rst_cnt_o=1.
4. Strap stability: change boot_mode_i to 2'b01 during RUN -> boot_mode_o stays 2'b10. Then pulse sw_rst_req_i -> soc_rst_no=0 for 8 cycles; boot_mode_o becomes 2'b01 on re-entry to RUN; rst_cnt_o unchanged.
5. Reset mid-HOLD: assert rst_ni at hold count 5 -> all outputs go to reset values immediately. On release, a full 8-cycle hold follows, and sw_rst_req_i pulses during HOLD restart the count.
6. Saturation: 260 debounced presses -> rst_cnt_o=255 with no wrap.
